xif_mem_arbiter: RTL
====================

Name: xif_mem_arbiter

Overview:
- N-port, parametrised successor to the core-local instruction/data memory arbiter.
- Merges NUM_PORTS 32-bit requestor ports (core instr, core data, coprocessor mem, …) onto one MEM_W-wide memory port.
- Tracks outstanding requests in an in-order FIFO and routes each response back to its originating port, selecting the correct 32-bit lane.
- New over the previous generation: memory-side backpressure (mem_gnt_i), selectable fixed/round-robin priority, bounded-depth tracking with a full stall, write-lane steering, and a protocol-error flag.

Parameters:
- NUM_PORTS, 2, number of requestor ports; must be ≥ 2.
- MEM_W, 32, memory data width; a power of two and ≥ 32.
- MAX_OUTST, 8, outstanding-request tracker depth; a power of two and ≥ 2.
- RR_MODE, 0, selects priority mode: 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- req_i  in  NUM_PORTS  per-port request.
- gnt_o  out  NUM_PORTS  per-port grant.
- addr_i  in  NUM_PORTS x 32  byte address, word aligned.
- we_i  in  NUM_PORTS  write enable.
- be_i  in  NUM_PORTS x 4  byte enables.
- wdata_i  in  NUM_PORTS x 32  write data.
- rvalid_o  out  NUM_PORTS  response valid.
- rdata_o  out  NUM_PORTS x 32  response data.
- err_o  out  NUM_PORTS  response error.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory accepts the request this cycle.
- mem_addr_o  out  32  request address.
- mem_we_o  out  1  request write enable.
- mem_be_o  out  MEM_W/8  request byte enables.
- mem_wdata_o  out  MEM_W  request write data.
- mem_rvalid_i  in  1  memory response valid.
- mem_err_i  in  1  memory response error.
- mem_rdata_i  in  MEM_W  memory response data.
- outstanding_o  out  $clog2(MAX_OUTST)+1  current tracker occupancy.
- proto_err_o  out  1  sticky flag: response arrived with an empty tracker.

Behaviour:
- Reset (synchronous, on rst_ni low at a clk_i edge):
  - Tracker emptied; outstanding_o = 0; proto_err_o = 0.
  - Round-robin pointer = 0.
  - All rvalid_o, err_o, gnt_o, mem_req_o = 0 while rst_ni is low.
- Arbitration (combinational):
  - The winner is chosen among ports with req_i high.
  - RR_MODE=0: the highest index wins.
  - RR_MODE=1: the first requesting port at or above the pointer wins, wrapping modulo NUM_PORTS.
- Request path:
  - mem_req_o = any req_i & ~full.
  - The mem_* request fields come from the winner.
  - When no port is requesting, the mem_* request fields come from port 0.
- Grant:
  - gnt_o[winner] = mem_req_o & mem_gnt_i. All other gnt_o bits are 0.
  - At most one gnt_o bit is high per cycle.
- Accepted request:
  - Defined as mem_req_o & mem_gnt_i at a clock edge.
  - Pushes {port id, lane = addr[$clog2(MEM_W/8)-1:2]} into the tracker.
  - RR_MODE=1: on acceptance the pointer becomes (winner+1) mod NUM_PORTS. The pointer is unchanged on any cycle without acceptance.
- Lane steering (write side):
  - mem_be_o = be_i zero-extended, shifted left by lane*4.
  - mem_wdata_o = 32-bit wdata replicated across all MEM_W/32 lanes.
  - When MEM_W = 32 the lane is always 0.
- Response:
  - On mem_rvalid_i, the tracker head is popped.
  - rvalid_o[head.port] = 1 in the same cycle (combinational from mem_rvalid_i).
  - rdata_o[p] = mem_rdata_i[head.lane*32 +: 32] for all p.
  - err_o[head.port] = mem_err_i. err_o is 0 for all other ports.
- Ordering:
  - Responses are strictly in order; memory must respond in acceptance order.
  - Response latency is not bounded by the block.
  - A response may arrive in the cycle after acceptance, at the earliest.
- Full tracker:
  - The tracker is full when occupancy = MAX_OUTST.
  - When full, mem_req_o = 0 and all gnt_o = 0.
  - A pop in the same cycle does NOT unblock the request; the request is re-evaluated next cycle (registered full, no comb path from mem_rvalid_i to mem_req_o).
- Simultaneous push and pop in one cycle: occupancy is unchanged; the head and tail pointers each advance, wrapping modulo MAX_OUTST.
- Empty-tracker response:
  - mem_rvalid_i with an empty tracker produces no rvalid_o.
  - proto_err_o is set and held until reset.
- Reset mid-operation: in-flight entries are discarded. Late responses after reset fall under the empty-tracker rule.
- Inputs from a port must stay stable while its req_i is high and it is not yet granted. This is a requestor obligation and is not checked.

Test Plan:
- Single port, MEM_W=128: port 1 reads 0x0000_0108, mem_gnt_i=1, response two cycles later with rdata words {W3,W2,W1,W0} → rvalid_o[1]=1, rdata_o[1]=W2, outstanding_o returns 0.
- Fixed priority, NUM_PORTS=3: req_i=3'b111 held for 3 cycles → gnt_o=3'b100 on every cycle.
- Round-robin, same stimulus → gnt_o sequence 001, 010, 100, 001.
- Backpressure: mem_gnt_i=0 for 4 cycles with req_i[0]=1 → gnt_o=0, no push. mem_gnt_i=1 → one grant, outstanding_o=1.
- Full stall, MAX_OUTST=4: 4 accepted reads with no responses → mem_req_o=0, outstanding_o=4. A response and a pending request in the same cycle → the request is granted in the next cycle, and outstanding_o goes 3 then 4.
- Write steering, MEM_W=64: port 0 writes addr 0x4, be=4'b0011, wdata=0xAABBCCDD → mem_be_o=8'b0011_0000, mem_wdata_o=0xAABBCCDD_AABBCCDD. A spurious mem_rvalid_i with an empty tracker → proto_err_o=1 and no rvalid_o.

Source files
------------

// File: rtl/xif_mem_arbiter.sv
// xif_mem_arbiter: merges NUM_PORTS 32-bit requestor ports onto a single MEM_W-wide
// memory port. An in-order tracker records {port, lane} for every accepted request.
// Each response goes back to the port at the tracker head, taking the 32-bit lane
// recorded for that request.
//
// Parameters
//   NUM_PORTS  number of requestor ports (>= 2)
//   MEM_W      memory data width (power of two, >= 32)
//   MAX_OUTST  tracker depth (power of two, >= 2)
//   RR_MODE    0: fixed priority (highest index wins), 1: round-robin
//
// Ports
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   req_i/gnt_o                    per-port request / grant
//   addr_i, we_i, be_i, wdata_i    per-port request fields
//   rvalid_o, rdata_o, err_o       per-port response
//   mem_req_o/mem_gnt_i            memory request handshake
//   mem_addr_o, mem_we_o,
//   mem_be_o, mem_wdata_o          memory request fields (lane steered)
//   mem_rvalid_i, mem_err_i,
//   mem_rdata_i                    memory response
//   outstanding_o                  tracker occupancy
//   proto_err_o                    sticky: response arrived with an empty tracker
module xif_mem_arbiter #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned MEM_W     = 32,
    parameter int unsigned MAX_OUTST = 8,
    parameter int unsigned RR_MODE   = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_PORTS-1:0]               req_i,
    output logic [NUM_PORTS-1:0]               gnt_o,
    input  logic [NUM_PORTS-1:0][31:0]         addr_i,
    input  logic [NUM_PORTS-1:0]               we_i,
    input  logic [NUM_PORTS-1:0][3:0]          be_i,
    input  logic [NUM_PORTS-1:0][31:0]         wdata_i,
    output logic [NUM_PORTS-1:0]               rvalid_o,
    output logic [NUM_PORTS-1:0][31:0]         rdata_o,
    output logic [NUM_PORTS-1:0]               err_o,
    output logic                               mem_req_o,
    input  logic                               mem_gnt_i,
    output logic [31:0]                        mem_addr_o,
    output logic                               mem_we_o,
    output logic [MEM_W/8-1:0]                 mem_be_o,
    output logic [MEM_W-1:0]                   mem_wdata_o,
    input  logic                               mem_rvalid_i,
    input  logic                               mem_err_i,
    input  logic [MEM_W-1:0]                   mem_rdata_i,
    output logic [$clog2(MAX_OUTST):0]         outstanding_o,
    output logic                               proto_err_o
);

    localparam int unsigned PortW    = $clog2(NUM_PORTS);
    localparam int unsigned PtrW     = $clog2(MAX_OUTST);
    localparam int unsigned CntW     = PtrW + 1;
    localparam int unsigned NumLanes = MEM_W / 32;
    // Keep lane signals at least one bit wide; they are tied to zero for MEM_W = 32.
    localparam int unsigned LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;

    // Wrap an index in [0, 2*NUM_PORTS) back into [0, NUM_PORTS) without a divider.
    function automatic int unsigned wrap_idx(input int unsigned a);
        return (a >= NUM_PORTS) ? a - NUM_PORTS : a;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [PortW-1:0] rr_ptr_q, rr_ptr_d;
    logic             proto_err_q, proto_err_d;

    logic [PortW-1:0] trk_port_q [MAX_OUTST];
    logic [LaneW-1:0] trk_lane_q [MAX_OUTST];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [PortW-1:0] winner;
    logic             found;
    logic             any_req;
    logic             full;
    logic             empty;
    logic             accept;
    logic             pop;

    assign any_req = |req_i;
    assign full    = (count_q == CntW'(MAX_OUTST));
    assign empty   = (count_q == '0);

    always_comb begin
        winner = '0;
        found  = 1'b0;
        if (RR_MODE != 0) begin
            // First requester at or above the pointer, wrapping around.
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                    if (!found && req_i[j] && (j == wrap_idx(k + int'(rr_ptr_q)))) begin
                        winner = PortW'(j);
                        found  = 1'b1;
                    end
                end
            end
        end else begin
            // Later iterations override earlier ones: highest index wins.
            for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                if (req_i[j]) begin
                    winner = PortW'(j);
                    found  = 1'b1;
                end
            end
        end
    end

    // Full is registered occupancy only; a same-cycle pop never unblocks the request.
    assign mem_req_o = rst_ni & any_req & ~full;
    assign accept    = mem_req_o & mem_gnt_i;

    always_comb begin
        gnt_o = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            gnt_o[p] = accept && (winner == PortW'(p));
        end
    end

    // ------------------------------------------------------------------
    // Request fields and write-lane steering
    // ------------------------------------------------------------------
    logic [LaneW-1:0]   req_lane;
    logic [MEM_W/8-1:0] be_ext;

    assign mem_addr_o  = addr_i[winner];
    assign mem_we_o    = we_i[winner];
    assign mem_wdata_o = {NumLanes{wdata_i[winner]}};

    if (NumLanes > 1) begin : g_req_lane
        assign req_lane = mem_addr_o[2 +: LaneW];
    end else begin : g_req_no_lane
        assign req_lane = '0;
    end

    always_comb begin
        be_ext      = '0;
        be_ext[3:0] = be_i[winner];
        mem_be_o    = be_ext << {req_lane, 2'b00};
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    logic [PortW-1:0] head_port;
    logic [LaneW-1:0] head_lane;
    logic [31:0]      resp_word;

    assign head_port = trk_port_q[rd_ptr_q];
    assign head_lane = trk_lane_q[rd_ptr_q];
    assign pop       = rst_ni & mem_rvalid_i & ~empty;

    if (NumLanes > 1) begin : g_resp_lane
        assign resp_word = mem_rdata_i[32*head_lane +: 32];
    end else begin : g_resp_no_lane
        assign resp_word = mem_rdata_i[31:0];
    end

    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            rdata_o[p] = resp_word;
            if (pop && (head_port == PortW'(p))) begin
                rvalid_o[p] = 1'b1;
                err_o[p]    = mem_err_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        proto_err_d = proto_err_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            rr_ptr_d = (winner == PortW'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!accept && pop) begin
            count_d = count_q - 1'b1;
        end
        if (mem_rvalid_i && empty) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rr_ptr_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Tracker payload needs no reset: entries are only read while occupancy covers them.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            trk_port_q[wr_ptr_q] <= winner;
            trk_lane_q[wr_ptr_q] <= req_lane;
        end
    end

    assign outstanding_o = count_q;
    assign proto_err_o   = proto_err_q;

endmodule
